// File: rtl/octave_stream_scheduler.sv
// Frame sequencer for the octave Gaussian datapath: gates the shared enable,
// flushes with zero pixels at frame end and tags each output with its window centre.
// Optional 2:1 decimation strobe (dec_valid) when OCTAVE_SCHED_DECIM_EN is defined.
module octave_stream_scheduler #(
    parameter int frameW     = 640,
    parameter int frameH     = 480,
    parameter int windowSize = 19,
    parameter int PIPE_LAT   = 12,
    parameter int XW         = $clog2(frameW),
    parameter int YW         = $clog2(frameH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          dp_en,
    output logic          dp_zero,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_border,
    output logic          out_last,
    output logic          busy,
    output logic          done
`ifdef OCTAVE_SCHED_DECIM_EN
    ,
    output logic          dec_valid
`endif
);

    localparam int R    = windowSize / 2;
    localparam int NPIX = frameW * frameH;
    localparam int D    = R * frameW + R + PIPE_LAT;
    localparam int NEN  = NPIX + D;
    localparam int NW   = $clog2(NPIX + 1);
    localparam int CW   = $clog2(NEN + 1);

    localparam logic [NW-1:0] N_LAST = NW'(NPIX - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NEN - 1);
    localparam logic [CW-1:0] C_D    = CW'(D);
    localparam logic [XW-1:0] X_LAST = XW'(frameW - 1);
    localparam logic [XW-1:0] X_LO   = XW'(R);
    localparam logic [XW-1:0] X_HI   = XW'(frameW - 1 - R);
    localparam logic [YW-1:0] Y_LAST = YW'(frameH - 1);
    localparam logic [YW-1:0] Y_LO   = YW'(R);
    localparam logic [YW-1:0] Y_HI   = YW'(frameH - 1 - R);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [CW-1:0] c_q, c_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          out_valid_q, out_valid_d;
    logic [XW-1:0] out_x_q, out_x_d;
    logic [YW-1:0] out_y_q, out_y_d;
    logic          out_border_q, out_border_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;

    always_comb begin
        in_ready = 1'b0;
        dp_en    = 1'b0;
        dp_zero  = 1'b0;
        case (state_q)
            S_FILL: begin
                in_ready = out_ready;
                dp_en    = in_valid & out_ready;
            end
            S_FLUSH: begin
                dp_zero = 1'b1;
                dp_en   = out_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        c_d          = c_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_border_d = out_border_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    n_d     = '0;
                    c_d     = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            S_FILL: begin
                if (dp_en) begin
                    n_d = n_q + 1'b1;
                    if (n_q == N_LAST) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (dp_en && c_q == C_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Tags move with the datapath output register: only on an enable edge.
        if (dp_en) begin
            c_d = c_q + 1'b1;
            if (c_q >= C_D) begin
                out_valid_d  = 1'b1;
                out_x_d      = cx_q;
                out_y_d      = cy_q;
                out_border_d = (cx_q < X_LO) | (cx_q > X_HI) |
                               (cy_q < Y_LO) | (cy_q > Y_HI);
                out_last_d   = (cx_q == X_LAST) & (cy_q == Y_LAST);
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (state_q == S_IDLE && out_ready) begin
            // Final result of a frame is consumed without an enable.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            c_q          <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_border_q <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            c_q          <= c_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_border_q <= out_border_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_border = out_border_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

`ifdef OCTAVE_SCHED_DECIM_EN
    assign dec_valid = out_valid_q & ~out_x_q[0] & ~out_y_q[0];
`endif

endmodule

// File: tb/tb_octave_stream_scheduler.sv
// Directed bench for octave_stream_scheduler on an 8x6 frame, 3x3 window, PIPE_LAT=2 (D=11).
module tb_octave_stream_scheduler;
    localparam int W = 8, H = 6, WS = 3, PL = 2, XW = 3, YW = 3;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, dp_en, dp_zero, out_valid, out_border, out_last, busy, done;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
`ifdef OCTAVE_SCHED_DECIM_EN
    logic dec_valid;
`endif

    octave_stream_scheduler #(.frameW(W), .frameH(H), .windowSize(WS), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .dp_en(dp_en), .dp_zero(dp_zero), .out_ready(out_ready), .out_valid(out_valid),
        .out_x(out_x), .out_y(out_y), .out_border(out_border), .out_last(out_last),
        .busy(busy), .done(done)
`ifdef OCTAVE_SCHED_DECIM_EN
        , .dec_valid(dec_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int k; int x; int y; int b; int l; int c; } vec_t;
    typedef struct { int x; int y; int b; int l; int c; } res_t;

    vec_t tbl[10];
    res_t res_q[$];
    res_t mon_r;
    int   tests = 0, failed = 0;
    int   ecnt, cyc, last_en_cyc, done_cyc, done_cnt, pix, viol, first_valid_ecnt;
    int   dec_cnt, dec_bad;
    bit   mon_on = 1'b0, seen_valid, prev_rn;
    logic [XW+YW+2:0] prev_tags;
    bit   to;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        res_q.delete();
        ecnt = 0; cyc = 0; last_en_cyc = -100; done_cyc = -1; done_cnt = 0;
        pix = 0; viol = 0; first_valid_ecnt = -1; dec_cnt = 0; dec_bad = 0;
        seen_valid = 1'b0; prev_rn = 1'b0; prev_tags = '0;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                first_valid_ecnt = ecnt;
            end
            if (out_valid && out_ready && (dp_en || !busy)) begin
                mon_r.x = int'(out_x); mon_r.y = int'(out_y);
                mon_r.b = int'(out_border); mon_r.l = int'(out_last);
                mon_r.c = ecnt - 1;
                res_q.push_back(mon_r);
`ifdef OCTAVE_SCHED_DECIM_EN
                if (dec_valid) begin
                    dec_cnt++;
                    if (out_x[0] || out_y[0]) dec_bad++;
                end
`endif
            end
            // With out_ready low last cycle there was no enable, so nothing may move.
            if (prev_rn && {out_valid, out_x, out_y, out_border, out_last} != prev_tags) viol++;
            if (busy && !dp_zero && !in_valid && dp_en) viol++;
            if (!out_ready && (dp_en || in_ready)) viol++;
            if (in_valid && in_ready) pix++;
            if (dp_en) begin ecnt++; last_en_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            prev_tags = {out_valid, out_x, out_y, out_border, out_last};
            prev_rn   = !out_ready;
            cyc++;
        end
    end

    // Entered at posedge+1; returns at posedge+1 of the cycle after done.
    task automatic run_frame(input bit tog, input bit stall, input bit extra_start,
                             input int rst_after, output bit tmo);
        int f = 0, fz = 0;
        clear_mon();
        mon_on = 1'b1;
        tmo = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            if (done_cnt > 0) break;
            f++;
            if (f > 600) begin tmo = 1'b1; break; end
            #1;
            start     = extra_start && (f == 30);
            in_valid  = tog ? ((f % 2) == 1) : 1'b1;
            out_ready = !(stall && ((f >= 20 && f < 25) || (f >= 60 && f < 65)));
            if (dp_zero) fz++;
            if (rst_after > 0 && fz >= rst_after) begin
                #2 rst_n = 1'b0;
                mon_on = 1'b0;
                #1;
                chk("async_reset_outputs",
                    int'({in_ready, dp_en, dp_zero, out_valid, out_x, out_y,
                          out_border, out_last, busy, done}), 0);
                return;
            end
        end
        #1;
        mon_on = 1'b0;
    endtask

    task automatic check_frame(input string nm, input bit tmo);
        int bad = 0;
        chk({nm, ".timeout"}, int'(tmo), 0);
        chk({nm, ".results"}, res_q.size(), 48);
        for (int k = 0; k < res_q.size() && k < 48; k++) begin
            int x = k % 8;
            int y = k / 8;
            int b = (x < 1 || x > 6 || y < 1 || y > 4) ? 1 : 0;
            int l = (k == 47) ? 1 : 0;
            if (res_q[k].x != x || res_q[k].y != y || res_q[k].b != b ||
                res_q[k].l != l || res_q[k].c != k + 11) bad++;
        end
        chk({nm, ".tag_seq_errors"}, bad, 0);
        chk({nm, ".en_cycles"}, ecnt, 59);
        chk({nm, ".done_pulses"}, done_cnt, 1);
        chk({nm, ".done_after_last_en"}, done_cyc - last_en_cyc, 1);
        chk({nm, ".pixels"}, pix, 48);
        chk({nm, ".protocol_errors"}, viol, 0);
        chk({nm, ".first_valid_after_en"}, first_valid_ecnt, 12);
        if (res_q.size() > 0) chk({nm, ".first_tag_xy"}, res_q[0].x * 16 + res_q[0].y, 0);
`ifdef OCTAVE_SCHED_DECIM_EN
        chk({nm, ".dec_strobes"}, dec_cnt, 12);
        chk({nm, ".dec_odd"}, dec_bad, 0);
`endif
    endtask

    initial begin
        tbl[0] = '{k: 0,  x: 0, y: 0, b: 1, l: 0, c: 11};
        tbl[1] = '{k: 1,  x: 1, y: 0, b: 1, l: 0, c: 12};
        tbl[2] = '{k: 9,  x: 1, y: 1, b: 0, l: 0, c: 20};
        tbl[3] = '{k: 14, x: 6, y: 1, b: 0, l: 0, c: 25};
        tbl[4] = '{k: 15, x: 7, y: 1, b: 1, l: 0, c: 26};
        tbl[5] = '{k: 16, x: 0, y: 2, b: 1, l: 0, c: 27};
        tbl[6] = '{k: 38, x: 6, y: 4, b: 0, l: 0, c: 49};
        tbl[7] = '{k: 39, x: 7, y: 4, b: 1, l: 0, c: 50};
        tbl[8] = '{k: 41, x: 1, y: 5, b: 1, l: 0, c: 52};
        tbl[9] = '{k: 47, x: 7, y: 5, b: 1, l: 1, c: 58};

        #12;
        chk("reset_outputs",
            int'({in_ready, dp_en, dp_zero, out_valid, out_x, out_y,
                  out_border, out_last, busy, done}), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(1'b0, 1'b0, 1'b0, 0, to);
        check_frame("plain", to);
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].k < res_q.size()) begin
                chk($sformatf("tbl%0d.tag", i),
                    res_q[tbl[i].k].x * 64 + res_q[tbl[i].k].y * 4 +
                    res_q[tbl[i].k].b * 2 + res_q[tbl[i].k].l,
                    tbl[i].x * 64 + tbl[i].y * 4 + tbl[i].b * 2 + tbl[i].l);
                chk($sformatf("tbl%0d.en_cycle", i), res_q[tbl[i].k].c, tbl[i].c);
            end else begin
                chk($sformatf("tbl%0d.present", i), res_q.size(), tbl[i].k + 1);
            end
        end

        run_frame(1'b1, 1'b0, 1'b0, 0, to);
        check_frame("toggle_b2b", to);

        run_frame(1'b0, 1'b1, 1'b0, 0, to);
        check_frame("stall", to);

        run_frame(1'b0, 1'b0, 1'b1, 0, to);
        check_frame("start_busy", to);

        run_frame(1'b0, 1'b0, 1'b0, 3, to);
        chk("rst_frame.timeout", int'(to), 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(1'b0, 1'b0, 1'b0, 0, to);
        check_frame("after_reset", to);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
